// File: rtl/adc_frame_tx_pkg.sv
// Shared definitions for the ADC sample framer: FSM encoding, header default,
// checksum width and the high-byte extraction helper.
package adc_frame_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_SEQ  = 3'd2,
    ST_HI   = 3'd3,
    ST_LO   = 3'd4,
    ST_CSUM = 3'd5
  } frame_state_t;

  localparam logic [7:0]  FRAME_HDR_DEFAULT = 8'hA5;
  localparam int unsigned CSUM_W            = 8;

  // Upper byte of a sample that has been zero-extended to 16 bits.
  function automatic logic [7:0] sample_hi(input logic [15:0] s);
    return s[15:8];
  endfunction

endpackage

// File: rtl/adc_frame_tx_sample_fifo.sv
// Single-clock show-ahead sample FIFO with level/full/empty flags.
module sample_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned AW    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_next,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] DEPTH   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] LVL_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nx;
  logic             do_push;
  logic             do_pop;

  assign full      = (level == DEPTH);
  assign empty     = (level == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign rd_ptr_nx = rd_ptr + AW'(1);

  // dout_next lets the consumer load the following sample on the same edge it pops.
  assign dout      = mem[rd_ptr];
  assign dout_next = mem[rd_ptr_nx];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr_nx;
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/adc_frame_tx.sv
// Frames buffered ADC samples (header, sequence, big-endian samples, checksum)
// and hands them byte by byte to the FT245 stage over TXEN/TX_DATA/TX_DONE.
module adc_frame_tx
  import adc_frame_tx_pkg::*;
#(
  parameter int unsigned ADC_WIDTH         = 12,
  parameter int unsigned FIFO_AW           = 4,
  parameter int unsigned SAMPLES_PER_FRAME = 4,
  parameter logic [7:0]  FRAME_HDR         = FRAME_HDR_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 SAMPLE_VALID,
  input  logic [ADC_WIDTH-1:0] SAMPLE_DATA,
  output logic [FIFO_AW:0]     FIFO_LEVEL,
  output logic                 FIFO_FULL,
  output logic                 OVERFLOW,
  output logic                 BUSY,
  output logic [7:0]           FRAME_SEQ,
  output logic                 TXEN,
  output logic [7:0]           TX_DATA,
  input  logic                 TX_DONE
);

  localparam logic [FIFO_AW:0] SPF     = (FIFO_AW+1)'(SAMPLES_PER_FRAME);
  localparam logic [FIFO_AW:0] CNT_ONE = (FIFO_AW+1)'(1);

  frame_state_t         state;
  logic                 txen_reg;
  logic [7:0]           tx_data_r;
  logic [CSUM_W-1:0]    csum;
  logic [CSUM_W-1:0]    csum_nx;
  logic [FIFO_AW:0]     sample_cnt;
  logic [FIFO_AW:0]     cnt_inc;
  logic [7:0]           seq;
  logic [ADC_WIDTH-1:0] head;
  logic [ADC_WIDTH-1:0] head_next;
  logic                 fifo_pop;
  logic                 fifo_empty;

  assign fifo_pop = (state == ST_LO) & TX_DONE;
  assign csum_nx  = csum + tx_data_r;
  assign cnt_inc  = sample_cnt + CNT_ONE;

  sample_fifo #(
    .WIDTH (ADC_WIDTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (SAMPLE_VALID),
    .din       (SAMPLE_DATA),
    .pop       (fifo_pop),
    .dout      (head),
    .dout_next (head_next),
    .level     (FIFO_LEVEL),
    .full      (FIFO_FULL),
    .empty     (fifo_empty)
  );

  // Checksum accumulates each byte after the header on that byte's TX_DONE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= ST_IDLE;
      txen_reg   <= 1'b0;
      tx_data_r  <= '0;
      csum       <= '0;
      sample_cnt <= '0;
      seq        <= '0;
    end else begin
      case (state)
        ST_IDLE: if (!fifo_empty && FIFO_LEVEL >= SPF) begin
          state     <= ST_HDR;
          tx_data_r <= FRAME_HDR;
          txen_reg  <= 1'b1;
        end
        ST_HDR: if (TX_DONE) begin
          state      <= ST_SEQ;
          tx_data_r  <= seq;
          csum       <= '0;
          sample_cnt <= '0;
        end
        ST_SEQ: if (TX_DONE) begin
          state     <= ST_HI;
          tx_data_r <= sample_hi(16'(head));
          csum      <= csum_nx;
        end
        ST_HI: if (TX_DONE) begin
          state     <= ST_LO;
          tx_data_r <= head[7:0];
          csum      <= csum_nx;
        end
        ST_LO: if (TX_DONE) begin
          sample_cnt <= cnt_inc;
          csum       <= csum_nx;
          if (cnt_inc < SPF) begin
            state     <= ST_HI;
            tx_data_r <= sample_hi(16'(head_next));
          end else begin
            state     <= ST_CSUM;
            tx_data_r <= csum_nx;
          end
        end
        ST_CSUM: if (TX_DONE) begin
          state    <= ST_IDLE;
          txen_reg <= 1'b0;
          seq      <= seq + 8'd1;
        end
        default: begin
          state    <= ST_IDLE;
          txen_reg <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                          OVERFLOW <= 1'b0;
    else if (SAMPLE_VALID && FIFO_FULL) OVERFLOW <= 1'b1;
  end

  assign TXEN      = txen_reg & ~TX_DONE;
  assign TX_DATA   = tx_data_r;
  assign BUSY      = (state != ST_IDLE);
  assign FRAME_SEQ = seq;

endmodule

// File: tb/tb_adc_frame_tx.sv
// Directed bench for adc_frame_tx: a sample/frame model fills a byte scoreboard,
// and an FT245 responder pops and compares each byte at its TX_DONE.
module tb_adc_frame_tx;

  logic        CLK = 1'b0;
  logic        RST;
  logic        SAMPLE_VALID;
  logic [11:0] SAMPLE_DATA;
  logic [4:0]  FIFO_LEVEL;
  logic        FIFO_FULL;
  logic        OVERFLOW;
  logic        BUSY;
  logic [7:0]  FRAME_SEQ;
  logic        TXEN;
  logic [7:0]  TX_DATA;
  logic        TX_DONE;

  int errors = 0;
  int checks = 0;

  logic [7:0]  exp_q[$];
  logic [11:0] m_q[$];
  logic [7:0]  m_seq = 8'h00;
  logic        m_ovf = 1'b0;

  bit          resp_en = 1'b1;
  int          resp_delay = 3;
  bit          stall_armed = 1'b0;
  bit          stall_hit = 1'b0;
  logic [7:0]  stall_byte = 8'h00;

  always #5 CLK = ~CLK;

  adc_frame_tx #(
    .ADC_WIDTH         (12),
    .FIFO_AW           (4),
    .SAMPLES_PER_FRAME (4),
    .FRAME_HDR         (8'hA5)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .SAMPLE_VALID (SAMPLE_VALID),
    .SAMPLE_DATA  (SAMPLE_DATA),
    .FIFO_LEVEL   (FIFO_LEVEL),
    .FIFO_FULL    (FIFO_FULL),
    .OVERFLOW     (OVERFLOW),
    .BUSY         (BUSY),
    .FRAME_SEQ    (FRAME_SEQ),
    .TXEN         (TXEN),
    .TX_DATA      (TX_DATA),
    .TX_DONE      (TX_DONE)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void build_frame();
    logic [7:0]  cs;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [11:0] s;
    exp_q.push_back(8'hA5);
    exp_q.push_back(m_seq);
    cs = m_seq;
    for (int i = 0; i < 4; i++) begin
      s  = m_q.pop_front();
      hi = {4'h0, s[11:8]};
      lo = s[7:0];
      exp_q.push_back(hi);
      exp_q.push_back(lo);
      cs = cs + hi + lo;
    end
    exp_q.push_back(cs);
    m_seq = m_seq + 8'd1;
  endfunction

  // Called at #1 after an edge; returns at #1 after the edge that samples the push.
  task automatic push(input logic [11:0] s);
    SAMPLE_DATA  = s;
    SAMPLE_VALID = 1'b1;
    @(posedge CLK); #1;
    SAMPLE_VALID = 1'b0;
    if (m_q.size() < 16) m_q.push_back(s);
    else                 m_ovf = 1'b1;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((exp_q.size() != 0 || BUSY) && n < maxc) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("idle_timeout", 32'(n < maxc), 32'd1);
  endtask

  // FT245 responder: answers TXEN with a TX_DONE pulse after resp_delay cycles.
  initial begin
    logic [7:0] rb;
    int         dly;
    bit         abort;
    TX_DONE = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (resp_en && RST && TXEN) begin
        rb  = TX_DATA;
        dly = resp_delay;
        if (stall_armed && rb == stall_byte) begin
          dly         = 50;
          stall_armed = 1'b0;
          stall_hit   = 1'b1;
        end
        abort = 1'b0;
        for (int i = 1; i < dly; i++) begin
          @(posedge CLK); #1;
          if (!resp_en || !RST) begin
            abort = 1'b1;
            break;
          end
          chk("tx_data_hold", TX_DATA, rb);
          chk("txen_wait", TXEN, 1);
        end
        if (!abort) begin
          TX_DONE = 1'b1;
          #1;
          chk("txen_gated", TXEN, 0);
          chk("tx_data_at_done", TX_DATA, rb);
          chk("byte_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) chk("byte", rb, exp_q.pop_front());
          @(posedge CLK); #1;
          TX_DONE = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] s0;
    int n;
    RST = 1'b0;
    SAMPLE_VALID = 1'b0;
    SAMPLE_DATA  = '0;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_txen", TXEN, 0);
    chk("rst_tx_data", TX_DATA, 8'h00);
    chk("rst_level", FIFO_LEVEL, 0);
    chk("rst_full", FIFO_FULL, 0);
    chk("rst_overflow", OVERFLOW, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_seq", FRAME_SEQ, 0);
    RST = 1'b1;
    @(posedge CLK); #1;

    // Threshold and basic frame
    push(12'h123); push(12'h456); push(12'h789);
    repeat (5) @(posedge CLK);
    #1;
    chk("thr_txen", TXEN, 0);
    chk("thr_busy", BUSY, 0);
    chk("thr_level", FIFO_LEVEL, 3);
    push(12'hABC);
    build_frame();
    chk("start_k_txen", TXEN, 0);
    chk("start_k_level", FIFO_LEVEL, 4);
    @(posedge CLK); #1;
    chk("start_k1_busy", BUSY, 1);
    chk("start_k1_txen", TXEN, 1);
    chk("start_k1_hdr", TX_DATA, 8'hA5);
    wait_idle(300);
    chk("basic_seq", FRAME_SEQ, 1);
    chk("basic_level", FIFO_LEVEL, 0);

    // Overflow: 17 pushes with the FT245 stage silent
    resp_en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      push(12'h100 + 12'(i));
      if (i == 15) begin
        chk("ovf_full16", FIFO_FULL, 1);
        chk("ovf_not_yet", OVERFLOW, 0);
      end
    end
    chk("ovf_level", FIFO_LEVEL, 16);
    chk("ovf_full", FIFO_FULL, 1);
    chk("ovf_flag", OVERFLOW, m_ovf);
    chk("ovf_hdr_waiting", TXEN, 1);
    while (m_q.size() >= 4) build_frame();
    #2;
    resp_en = 1'b1;
    wait_idle(1500);
    chk("ovf_drained", FIFO_LEVEL, 0);
    chk("ovf_sticky", OVERFLOW, 1);
    chk("ovf_seq", FRAME_SEQ, m_seq);

    // Back-pressure on byte 0x56
    stall_byte  = 8'h56;
    stall_armed = 1'b1;
    stall_hit   = 1'b0;
    push(12'h123); push(12'h456); push(12'h789); push(12'hABC);
    build_frame();
    wait_idle(500);
    chk("stall_seen", stall_hit, 1);

    // Sequence wrap through FF
    resp_delay = 1;
    do begin
      for (int i = 0; i < 4; i++) push(12'($urandom_range(0, 4095)));
      build_frame();
      wait_idle(300);
    end while (m_seq != 8'h00);
    chk("wrap_seq", FRAME_SEQ, 0);

    // Reset during HI
    resp_delay = 3;
    s0 = 12'h3C7;
    push(s0); push(12'h111); push(12'h222); push(12'h333);
    exp_q.push_back(8'hA5);
    exp_q.push_back(m_seq);
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge CLK); #1;
      n++;
    end
    while (!TXEN && n < 300) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("hi_reached", 32'(n < 300), 1);
    chk("hi_byte", TX_DATA, {4'h0, s0[11:8]});
    #2;
    resp_en = 1'b0;
    RST     = 1'b0;
    #1;
    chk("mid_rst_txen", TXEN, 0);
    chk("mid_rst_tx_data", TX_DATA, 8'h00);
    chk("mid_rst_level", FIFO_LEVEL, 0);
    chk("mid_rst_full", FIFO_FULL, 0);
    chk("mid_rst_overflow", OVERFLOW, 0);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_seq", FRAME_SEQ, 0);
    m_q.delete();
    m_seq = 8'h00;
    m_ovf = 1'b0;
    repeat (3) @(posedge CLK);
    #3;
    RST     = 1'b1;
    resp_en = 1'b1;
    @(posedge CLK); #1;
    chk("post_rst_idle", BUSY, 0);
    push(12'h0F0); push(12'hF0F); push(12'h5A5); push(12'hA5A);
    build_frame();
    wait_idle(300);
    chk("post_rst_seq", FRAME_SEQ, 1);
    chk("post_rst_level", FIFO_LEVEL, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
